// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package pll_sup_pkg;

  // One-hot sequencing states
  typedef enum logic [3:0] {
    PLL_RST   = 4'b0001,
    WAIT_LOCK = 4'b0010,
    STABLE    = 4'b0100,
    RUN       = 4'b1000
  } state_e;

  // Width of the retry/lost statistics counters
  localparam int unsigned CNT_W = 8;

  // Largest of three cycle parameters; sizes the shared state counter
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Generic 1-bit two-stage synchronizer with synchronous reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic ff1_q;
  logic ff2_q;

  // Two back-to-back flops; first stage may go metastable, second resolves
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, qualifies lock stability and holds the system reset
// until lock has been stable; counts timeouts and lock losses.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned STABLE_CYCLES       = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lock,
  output logic             pll_reset,
  output logic             sys_reset,
  output logic             locked_ok,
  output logic             timeout_pulse,
  output logic [CNT_W-1:0] retry_count,
  output logic [CNT_W-1:0] lost_count
);

  localparam int unsigned CW =
    $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES)) + 1;
  localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

  logic             lock_s;
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             timeout_evt, lost_evt;

  logic             pll_reset_q, pll_reset_d;
  logic             sys_reset_q, sys_reset_d;
  logic             locked_ok_q, locked_ok_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] retry_q, retry_d;
  logic [CNT_W-1:0] lost_q, lost_d;

  sync_2ff u_lock_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (lock),
    .q_o   (lock_s)
  );

  // State register and shared per-state cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PLL_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state decode; lock_s takes priority over counter expiry
  always_comb begin
    state_d     = state_q;
    timeout_evt = 1'b0;
    lost_evt    = 1'b0;
    unique case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d     = PLL_RST;
          timeout_evt = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s)                    state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST)  state_d = RUN;
      end
      RUN: begin
        if (!lock_s) begin
          state_d  = PLL_RST;
          lost_evt = 1'b1;
        end
      end
      default: state_d = PLL_RST;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(1);
  end

  // Output decode from next state so pins move on the same edge as the state
  always_comb begin
    pll_reset_d = (state_d == PLL_RST);
    sys_reset_d = (state_d != RUN);
    locked_ok_d = (state_d == RUN);
    timeout_d   = timeout_evt;
    retry_d     = (timeout_evt && (retry_q != '1)) ? retry_q + CNT_W'(1) : retry_q;
    lost_d      = (lost_evt && (lost_q != '1)) ? lost_q + CNT_W'(1) : lost_q;
  end

  // Output and statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pll_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      locked_ok_q <= 1'b0;
      timeout_q   <= 1'b0;
      retry_q     <= '0;
      lost_q      <= '0;
    end else begin
      pll_reset_q <= pll_reset_d;
      sys_reset_q <= sys_reset_d;
      locked_ok_q <= locked_ok_d;
      timeout_q   <= timeout_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
    end
  end

  assign pll_reset     = pll_reset_q;
  assign sys_reset     = sys_reset_q;
  assign locked_ok     = locked_ok_q;
  assign timeout_pulse = timeout_q;
  assign retry_count   = retry_q;
  assign lost_count    = lost_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench for pll_lock_supervisor (4/100/16 cycles).
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       lock = 1'b0;
  logic       pll_reset, sys_reset, locked_ok, timeout_pulse;
  logic [7:0] retry_count, lost_count;

  int n_pass = 0;
  int n_total = 0;

  always #10 clk = ~clk;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES      (4),
    .LOCK_TIMEOUT_CYCLES (100),
    .STABLE_CYCLES       (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .lock          (lock),
    .pll_reset     (pll_reset),
    .sys_reset     (sys_reset),
    .locked_ok     (locked_ok),
    .timeout_pulse (timeout_pulse),
    .retry_count   (retry_count),
    .lost_count    (lost_count)
  );

  // Reset for two edges; release #1 after an edge so the next edge is cycle 1
  task automatic do_reset(input logic lock_v);
    lock = lock_v;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    lock = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    n_total++; if ({pll_reset, sys_reset, locked_ok, timeout_pulse} !== 4'b1100) $display("FAIL reset_flags got %b want 1100", {pll_reset, sys_reset, locked_ok, timeout_pulse}); else n_pass++;
    n_total++; if ({retry_count, lost_count} !== 16'h0000) $display("FAIL reset_counters got %h want 0000", {retry_count, lost_count}); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_clean_start();
    int fall_pll, fall_sys, pll_hi, bad_cnt;
    fall_pll = -1; fall_sys = -1; pll_hi = 0; bad_cnt = 0;
    do_reset(1'b1);
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (pll_reset) pll_hi++;
      if (fall_pll < 0 && !pll_reset) fall_pll = k;
      if (fall_sys < 0 && !sys_reset) fall_sys = k;
      if (retry_count != 0 || lost_count != 0 || timeout_pulse) bad_cnt++;
    end
    n_total++; if (fall_pll !== 4) $display("FAIL clean_pll_fall got %0d want 4", fall_pll); else n_pass++;
    n_total++; if (pll_hi !== 3) $display("FAIL clean_pll_high_cycles got %0d want 3", pll_hi); else n_pass++;
    n_total++; if (fall_sys !== 21) $display("FAIL clean_sys_fall got %0d want 21", fall_sys); else n_pass++;
    n_total++; if (locked_ok !== 1'b1) $display("FAIL clean_locked_ok got %b want 1", locked_ok); else n_pass++;
    n_total++; if (bad_cnt !== 0) $display("FAIL clean_counters got %0d bad cycles want 0", bad_cnt); else n_pass++;
  endtask

  task automatic test_no_lock();
    int np, pll_hi, sys_lo;
    int t[3];
    np = 0; pll_hi = 0; sys_lo = 0;
    t[0] = -1; t[1] = -1; t[2] = -1;
    do_reset(1'b0);
    for (int k = 1; k <= 350; k++) begin
      @(posedge clk); #1;
      if (timeout_pulse) begin
        if (np < 3) t[np] = k;
        np++;
      end
      if (pll_reset) pll_hi++;
      if (!sys_reset) sys_lo++;
    end
    n_total++; if (np !== 3) $display("FAIL nolock_pulse_count got %0d want 3", np); else n_pass++;
    n_total++; if (t[0] !== 104 || t[1] !== 208 || t[2] !== 312) $display("FAIL nolock_pulse_times got %0d %0d %0d want 104 208 312", t[0], t[1], t[2]); else n_pass++;
    n_total++; if (pll_hi !== 15) $display("FAIL nolock_pll_high_cycles got %0d want 15", pll_hi); else n_pass++;
    n_total++; if (sys_lo !== 0) $display("FAIL nolock_sys_low got %0d want 0", sys_lo); else n_pass++;
    n_total++; if (retry_count !== 8'd3) $display("FAIL nolock_retry got %0d want 3", retry_count); else n_pass++;
  endtask

  // lock_s rises exactly on the last WAIT_LOCK cycle: lock must win
  task automatic test_timeout_tie();
    int np, fall_sys;
    np = 0; fall_sys = -1;
    do_reset(1'b0);
    for (int k = 1; k <= 130; k++) begin
      @(posedge clk); #1;
      if (timeout_pulse) np++;
      if (fall_sys < 0 && !sys_reset) fall_sys = k;
      if (k == 101) lock = 1'b1;
    end
    n_total++; if (np !== 0) $display("FAIL tie_pulses got %0d want 0", np); else n_pass++;
    n_total++; if (retry_count !== 8'd0) $display("FAIL tie_retry got %0d want 0", retry_count); else n_pass++;
    n_total++; if (fall_sys !== 120) $display("FAIL tie_sys_fall got %0d want 120", fall_sys); else n_pass++;
  endtask

  task automatic test_glitch_stable();
    int fall_sys, pll_hi;
    fall_sys = -1; pll_hi = 0;
    do_reset(1'b1);
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      if (pll_reset) pll_hi++;
      if (fall_sys < 0 && !sys_reset) fall_sys = k;
      if (k == 14) lock = 1'b0;
      if (k == 15) lock = 1'b1;
    end
    n_total++; if (fall_sys !== 34) $display("FAIL glitch_sys_fall got %0d want 34", fall_sys); else n_pass++;
    n_total++; if (pll_hi !== 3) $display("FAIL glitch_pll_high_cycles got %0d want 3", pll_hi); else n_pass++;
    n_total++; if (retry_count !== 8'd0) $display("FAIL glitch_retry got %0d want 0", retry_count); else n_pass++;
    n_total++; if (locked_ok !== 1'b1) $display("FAIL glitch_locked_ok got %b want 1", locked_ok); else n_pass++;
  endtask

  task automatic test_loss_in_run();
    int fall_pll, fall_sys;
    fall_pll = -1; fall_sys = -1;
    do_reset(1'b1);
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == 27) begin
        n_total++; if (sys_reset !== 1'b0) $display("FAIL loss_sys_before got %b want 0", sys_reset); else n_pass++;
      end
      if (k == 28) begin
        n_total++; if ({sys_reset, pll_reset, locked_ok} !== 3'b110) $display("FAIL loss_rise got %b want 110", {sys_reset, pll_reset, locked_ok}); else n_pass++;
        n_total++; if (lost_count !== 8'd1) $display("FAIL loss_count got %0d want 1", lost_count); else n_pass++;
      end
      if (k > 28 && fall_pll < 0 && !pll_reset) fall_pll = k;
      if (k > 28 && fall_sys < 0 && !sys_reset) fall_sys = k;
      if (k == 25) lock = 1'b0;
      if (k == 30) lock = 1'b1;
    end
    n_total++; if (fall_pll !== 32) $display("FAIL loss_pll_fall got %0d want 32", fall_pll); else n_pass++;
    n_total++; if (fall_sys !== 49) $display("FAIL loss_sys_fall got %0d want 49", fall_sys); else n_pass++;
    n_total++; if (lost_count !== 8'd1 || retry_count !== 8'd0) $display("FAIL loss_final_counts got %0d/%0d want 1/0", lost_count, retry_count); else n_pass++;
  endtask

  task automatic test_reset_mid_stable();
    int fall_pll, fall_sys;
    fall_pll = -1; fall_sys = -1;
    do_reset(1'b1);
    for (int k = 1; k <= 38; k++) begin
      @(posedge clk); #1;
      if (k == 25) lock = 1'b0;
      if (k == 30) lock = 1'b1;
    end
    n_total++; if ({lost_count, sys_reset, pll_reset} !== {8'd1, 2'b10}) $display("FAIL midrst_precond got lost=%0d sys=%b pll=%b want 1 1 0", lost_count, sys_reset, pll_reset); else n_pass++;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_total++; if ({pll_reset, sys_reset, locked_ok, timeout_pulse} !== 4'b1100) $display("FAIL midrst_flags got %b want 1100", {pll_reset, sys_reset, locked_ok, timeout_pulse}); else n_pass++;
    n_total++; if ({retry_count, lost_count} !== 16'h0000) $display("FAIL midrst_counters got %h want 0000", {retry_count, lost_count}); else n_pass++;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (fall_pll < 0 && !pll_reset) fall_pll = k;
      if (fall_sys < 0 && !sys_reset) fall_sys = k;
    end
    n_total++; if (fall_pll !== 4 || fall_sys !== 21) $display("FAIL midrst_restart got pll=%0d sys=%0d want 4 21", fall_pll, fall_sys); else n_pass++;
  endtask

  task automatic test_saturation();
    int np, last, r254, r256;
    np = 0; last = -1; r254 = -1; r256 = -1;
    do_reset(1'b0);
    for (int k = 1; k <= 31300 && np < 300; k++) begin
      @(posedge clk); #1;
      if (timeout_pulse) begin
        np++;
        last = k;
        if (np == 254) r254 = retry_count;
        if (np == 256) r256 = retry_count;
      end
    end
    n_total++; if (np !== 300) $display("FAIL sat_pulse_count got %0d want 300", np); else n_pass++;
    n_total++; if (last !== 31200) $display("FAIL sat_last_pulse got %0d want 31200", last); else n_pass++;
    n_total++; if (r254 !== 254) $display("FAIL sat_retry_254 got %0d want 254", r254); else n_pass++;
    n_total++; if (r256 !== 255) $display("FAIL sat_retry_256 got %0d want 255", r256); else n_pass++;
    n_total++; if (retry_count !== 8'd255) $display("FAIL sat_retry_final got %0d want 255", retry_count); else n_pass++;
    n_total++; if (pll_reset !== 1'b1 || sys_reset !== 1'b1) $display("FAIL sat_seq got pll=%b sys=%b want 1 1", pll_reset, sys_reset); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean_start();
    test_no_lock();
    test_timeout_tie();
    test_glitch_stable();
    test_loss_in_run();
    test_reset_mid_stable();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
